// File: rtl/fcpu_cram_rd_arbiter_pkg.sv
// Shared types and constants for the code-RAM read-port arbiter.
package fcpu_cram_rd_arbiter_pkg;

  localparam int CRAM_ID_W   = 4;
  localparam int CRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

  // Two-way round-robin pick: 0 selects m0, 1 selects m1.
  // On contention the master that was not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction

endpackage

// File: rtl/fcpu_cram_rd_arbiter_if.sv
// AXI4 read address/data channel bundle used on both sides of the arbiter.
interface fcpu_cram_rd_arbiter_if
  import fcpu_cram_rd_arbiter_pkg::*;
#(
  parameter int ID_W   = CRAM_ID_W,
  parameter int ADDR_W = 32,
  parameter int DATA_W = CRAM_DATA_W
) ();

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/fcpu_cram_rd_arbiter.sv
// Shares the single code-RAM AXI read port between instruction fetch (m0)
// and data load (m1). One whole burst is granted at a time, masters alternate
// under contention, and only one transaction is ever outstanding.
module fcpu_cram_rd_arbiter
  import fcpu_cram_rd_arbiter_pkg::*;
#(
  parameter int ID_W   = CRAM_ID_W,
  parameter int ADDR_W = 32,
  parameter int DATA_W = CRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  fcpu_cram_rd_arbiter_if.slave  m0,
  fcpu_cram_rd_arbiter_if.slave  m1,
  fcpu_cram_rd_arbiter_if.master s
);

  arb_state_t state, next_state;
  logic       g, next_g;
  logic       lg, next_lg;

  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              ar_valid;
  logic              r_ready;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;

  // The masters' lock/cache/prot/qos hints are not forwarded; the RAM ignores them.
  logic unused_ok;
  assign unused_ok = ^{m0.arlock, m0.arcache, m0.arprot, m0.arqos,
                       m1.arlock, m1.arcache, m1.arprot, m1.arqos};

  // State, grant and last-served registers; lg starts at m1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      g     <= 1'b0;
      lg    <= 1'b1;
    end else begin
      state <= next_state;
      g     <= next_g;
      lg    <= next_lg;
    end
  end

  // Arbitrate only in idle, then walk the burst through address and data phases.
  always_comb begin
    next_state = state;
    next_g     = g;
    next_lg    = lg;
    case (state)
      ARB_IDLE: begin
        if (m0.arvalid || m1.arvalid) begin
          next_g     = rr_pick(m0.arvalid, m1.arvalid, lg);
          next_state = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (ar_valid && s.arready) begin
          next_state = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (s.rvalid && r_ready && s.rlast) begin
          next_lg    = g;
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Address channel: the granted master's request is steered to the slave, valid only in ARB_ADDR.
  always_comb begin
    ar_id    = g ? m1.arid    : m0.arid;
    ar_addr  = g ? m1.araddr  : m0.araddr;
    ar_len   = g ? m1.arlen   : m0.arlen;
    ar_size  = g ? m1.arsize  : m0.arsize;
    ar_burst = g ? m1.arburst : m0.arburst;
    ar_valid = (state == ARB_ADDR) && (g ? m1.arvalid : m0.arvalid);
  end

  assign s.arid    = ar_id;
  assign s.araddr  = ar_addr;
  assign s.arlen   = ar_len;
  assign s.arsize  = ar_size;
  assign s.arburst = ar_burst;
  assign s.arvalid = ar_valid;
  assign s.arlock  = 1'b0;
  assign s.arcache = 4'd0;
  assign s.arprot  = 3'd0;
  assign s.arqos   = 4'd0;

  assign m0.arready = (state == ARB_ADDR) && !g && s.arready;
  assign m1.arready = (state == ARB_ADDR) &&  g && s.arready;

  // Data channel: payload fans out to both masters; only the granted one sees valid, and only its ready reaches the slave.
  always_comb begin
    r_id    = s.rid;
    r_data  = s.rdata;
    r_ready = (state == ARB_DATA) && (g ? m1.rready : m0.rready);
  end

  assign s.rready = r_ready;

  assign m0.rid    = r_id;
  assign m0.rdata  = r_data;
  assign m0.rresp  = s.rresp;
  assign m0.rlast  = s.rlast;
  assign m0.rvalid = (state == ARB_DATA) && !g && s.rvalid;

  assign m1.rid    = r_id;
  assign m1.rdata  = r_data;
  assign m1.rresp  = s.rresp;
  assign m1.rlast  = s.rlast;
  assign m1.rvalid = (state == ARB_DATA) &&  g && s.rvalid;

endmodule

// File: tb/tb_fcpu_cram_rd_arbiter.sv
// Scoreboard bench for the code-RAM read arbiter: directed master requests,
// a behavioural block-RAM slave, and a negedge monitor popping expectations.
module tb_fcpu_cram_rd_arbiter;
  import fcpu_cram_rd_arbiter_pkg::*;

  localparam logic [3:0] M0_ID = 4'h3;
  localparam logic [3:0] M1_ID = 4'hC;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic        mst;
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } r_t;

  logic clk;
  logic rst;
  logic ar_ready_en;

  fcpu_cram_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m0_if ();
  fcpu_cram_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m1_if ();
  fcpu_cram_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) s_if ();

  fcpu_cram_rd_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  ar_t exp_ar_q[$];
  r_t  exp_r_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  last_rlast_cyc = 0;
  int  ar_gap = 0;
  int  beats0 = 0;
  int  beats1 = 0;
  logic tb_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Slave RAM content model: beat i of a burst at addr returns (addr ^ 0x1A0) + i.
  function automatic logic [31:0] slv_data(input logic [31:0] addr, input int i);
    return (addr ^ 32'h0000_01A0) + 32'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural block-RAM slave: accepts one AR when idle, then streams beats honouring rready.
  logic        slv_busy;
  logic [31:0] slv_addr;
  logic [7:0]  slv_len;
  logic [7:0]  slv_beat;

  assign s_if.arready = ar_ready_en && !slv_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_busy    <= 1'b0;
      slv_addr    <= '0;
      slv_len     <= '0;
      slv_beat    <= '0;
      s_if.rvalid <= 1'b0;
      s_if.rlast  <= 1'b0;
      s_if.rdata  <= '0;
      s_if.rid    <= '0;
      s_if.rresp  <= 2'b00;
    end else if (!slv_busy) begin
      if (s_if.arvalid && s_if.arready) begin
        slv_busy    <= 1'b1;
        slv_addr    <= s_if.araddr;
        slv_len     <= s_if.arlen;
        slv_beat    <= 8'd0;
        s_if.rvalid <= 1'b1;
        s_if.rid    <= s_if.arid;
        s_if.rdata  <= slv_data(s_if.araddr, 0);
        s_if.rlast  <= (s_if.arlen == 8'd0);
      end
    end else if (s_if.rvalid && s_if.rready) begin
      if (s_if.rlast) begin
        s_if.rvalid <= 1'b0;
        s_if.rlast  <= 1'b0;
        slv_busy    <= 1'b0;
      end else begin
        slv_beat   <= slv_beat + 8'd1;
        s_if.rdata <= slv_data(slv_addr, int'(slv_beat) + 1);
        s_if.rlast <= ((slv_beat + 8'd1) == slv_len);
      end
    end
  end

  task automatic got_beat(input logic mst, input logic [3:0] id, input logic [31:0] data,
                          input logic last);
    r_t e;
    if (exp_r_q.size() == 0) begin
      check("unexpected_r_beat", {mst, id, data, last}, 64'h0);
    end else begin
      e = exp_r_q.pop_front();
      check("r_beat", {mst, id, data, last}, {e.mst, e.id, e.data, e.last});
    end
    if (mst) beats1 <= beats1 + 1;
    else     beats0 <= beats0 + 1;
    if (last) begin
      tb_busy        <= 1'b0;
      last_rlast_cyc <= cyc;
    end
  endtask

  // Monitor: pops the scoreboard on every AR and R handshake and watches the hold-off rules.
  always @(negedge clk) begin
    if (rst) begin
      exp_r_q.delete();
      tb_busy <= 1'b0;
    end else begin
      if (tb_busy) check("arready_while_busy", {m0_if.arready, m1_if.arready}, 0);
      if (m0_if.rvalid || m1_if.rvalid) check("both_rvalid", m0_if.rvalid & m1_if.rvalid, 0);
      if (s_if.arvalid && s_if.arready) begin
        ar_t e;
        if (exp_ar_q.size() == 0) begin
          check("unexpected_ar", {s_if.arid, s_if.araddr, s_if.arlen}, 64'h0);
        end else begin
          e = exp_ar_q.pop_front();
          check("ar_fwd", {s_if.arid, s_if.araddr, s_if.arlen}, {e.id, e.addr, e.len});
        end
        ar_gap  <= cyc - last_rlast_cyc;
        tb_busy <= 1'b1;
      end
      if (m0_if.rvalid && m0_if.rready) got_beat(1'b0, m0_if.rid, m0_if.rdata, m0_if.rlast);
      if (m1_if.rvalid && m1_if.rready) got_beat(1'b1, m1_if.rid, m1_if.rdata, m1_if.rlast);
    end
  end

  task automatic push_burst(input logic mst, input logic [31:0] addr, input logic [7:0] len);
    ar_t a;
    r_t  r;
    a.id   = mst ? M1_ID : M0_ID;
    a.addr = addr;
    a.len  = len;
    exp_ar_q.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      r.mst  = mst;
      r.id   = a.id;
      r.data = slv_data(addr, i);
      r.last = (i == int'(len));
      exp_r_q.push_back(r);
    end
  endtask

  task automatic applyStimulus_m0(input logic [31:0] addr, input logic [7:0] len);
    int n;
    @(negedge clk);
    m0_if.arid    = M0_ID;
    m0_if.araddr  = addr;
    m0_if.arlen   = len;
    m0_if.arsize  = 3'd2;
    m0_if.arburst = 2'b01;
    m0_if.arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m0_if.arready && n < 300);
    check("m0_ar_accepted", m0_if.arready, 1);
    @(posedge clk);
    #1 m0_if.arvalid = 1'b0;
  endtask

  task automatic applyStimulus_m1(input logic [31:0] addr, input logic [7:0] len);
    int n;
    @(negedge clk);
    m1_if.arid    = M1_ID;
    m1_if.araddr  = addr;
    m1_if.arlen   = len;
    m1_if.arsize  = 3'd2;
    m1_if.arburst = 2'b01;
    m1_if.arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m1_if.arready && n < 300);
    check("m1_ar_accepted", m1_if.arready, 1);
    @(posedge clk);
    #1 m1_if.arvalid = 1'b0;
  endtask

  task automatic checkOutput_done(input string name);
    int n;
    n = 0;
    while ((exp_ar_q.size() != 0 || exp_r_q.size() != 0 || tb_busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, (exp_ar_q.size() == 0 && exp_r_q.size() == 0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkOutput_reset(input string name);
    check({name, "_valids"}, {s_if.arvalid, s_if.rready, m0_if.arready, m1_if.arready,
                              m0_if.rvalid, m1_if.rvalid}, 6'b0);
    check({name, "_state"}, {dut.state, dut.g, dut.lg}, {ARB_IDLE, 1'b0, 1'b1});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int b0;
    rst         = 1'b1;
    ar_ready_en = 1'b1;
    m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0; m0_if.arburst = '0;
    m0_if.arlock = 1'b0; m0_if.arcache = '0; m0_if.arprot = '0; m0_if.arqos = '0;
    m0_if.arvalid = 1'b0; m0_if.rready = 1'b1;
    m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0; m1_if.arburst = '0;
    m1_if.arlock = 1'b0; m1_if.arcache = '0; m1_if.arprot = '0; m1_if.arqos = '0;
    m1_if.arvalid = 1'b0; m1_if.rready = 1'b1;

    // Reset state and tied-off slave sideband.
    repeat (2) @(negedge clk);
    checkOutput_reset("reset");
    check("ar_sideband", {s_if.arlock, s_if.arcache, s_if.arprot, s_if.arqos}, 0);
    rst = 1'b0;

    // m0 alone: 4 beats 0xA0..0xA3, address presented one cycle after arvalid.
    $display("[TB] m0 single burst");
    begin
      ar_t a;
      r_t  r;
      a.id = M0_ID; a.addr = 32'h100; a.len = 8'd3;
      exp_ar_q.push_back(a);
      r.mst = 1'b0; r.id = M0_ID;
      r.data = 32'hA0; r.last = 1'b0; exp_r_q.push_back(r);
      r.data = 32'hA1; r.last = 1'b0; exp_r_q.push_back(r);
      r.data = 32'hA2; r.last = 1'b0; exp_r_q.push_back(r);
      r.data = 32'hA3; r.last = 1'b1; exp_r_q.push_back(r);
    end
    fork
      applyStimulus_m0(32'h100, 8'd3);
      begin
        @(negedge clk);
        @(negedge clk);
        check("ar_latency", {s_if.arvalid, s_if.araddr}, {1'b1, 32'h100});
      end
    join
    checkOutput_done("m0_single_done");

    // Simultaneous requests after reset: m0 first, m1 two cycles after m0's rlast.
    $display("[TB] simultaneous requests after reset");
    pulse_reset();
    push_burst(1'b0, 32'h000, 8'd0);
    push_burst(1'b1, 32'h040, 8'd1);
    fork
      applyStimulus_m0(32'h000, 8'd0);
      applyStimulus_m1(32'h040, 8'd1);
    join
    checkOutput_done("tie_done");
    check("turnaround_gap", ar_gap, 2);

    // Continuous contention: strict alternation m0,m1,m0,m1,m0,m1.
    $display("[TB] continuous contention");
    for (int i = 0; i < 3; i++) begin
      push_burst(1'b0, 32'h200 + 32'(i * 16), 8'd1);
      push_burst(1'b1, 32'h300 + 32'(i * 16), 8'd2);
    end
    fork
      for (int i = 0; i < 3; i++) applyStimulus_m0(32'h200 + 32'(i * 16), 8'd1);
      for (int j = 0; j < 3; j++) applyStimulus_m1(32'h300 + 32'(j * 16), 8'd2);
    join
    checkOutput_done("contention_done");

    // m1 backpressure with rlast pending.
    $display("[TB] m1 rready backpressure");
    push_burst(1'b1, 32'h400, 8'd3);
    b0 = beats1;
    fork
      applyStimulus_m1(32'h400, 8'd3);
      begin
        int n;
        n = 0;
        while (beats1 < b0 + 3 && n < 300) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_reached_beat3", beats1 - b0, 3);
        m1_if.rready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_s_rready", s_if.rready, 0);
          check("bp_state", dut.state, ARB_DATA);
          check("bp_rlast_pending", {m1_if.rvalid, m1_if.rlast}, 2'b11);
          @(posedge clk);
          #1;
        end
        m1_if.rready = 1'b1;
      end
    join
    checkOutput_done("bp_done");

    // Slave stalls the address for 5 cycles while m1 starts requesting.
    $display("[TB] address stall with competing request");
    ar_ready_en = 1'b0;
    push_burst(1'b0, 32'h500, 8'd1);
    push_burst(1'b1, 32'h600, 8'd0);
    fork
      applyStimulus_m0(32'h500, 8'd1);
      begin
        @(negedge clk);
        @(negedge clk);
        applyStimulus_m1(32'h600, 8'd0);
      end
      begin
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          check("stall_grant_m0", {s_if.arvalid, s_if.arid}, {1'b1, M0_ID});
          check("stall_arready", {m0_if.arready, m1_if.arready}, 2'b00);
        end
        @(posedge clk);
        #1 ar_ready_en = 1'b1;
      end
    join
    checkOutput_done("stall_done");

    // Asynchronous reset in the middle of a 16-beat burst, then a clean m1 burst.
    $display("[TB] reset mid-burst");
    push_burst(1'b0, 32'h800, 8'd15);
    b0 = beats0;
    applyStimulus_m0(32'h800, 8'd15);
    begin
      int n;
      n = 0;
      while (beats0 < b0 + 5 && n < 300) begin
        @(posedge clk);
        n++;
      end
      check("mid_burst_reached", beats0 - b0 >= 5, 1);
    end
    #3 rst = 1'b1;
    #1 checkOutput_reset("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_burst(1'b1, 32'h700, 8'd2);
    applyStimulus_m1(32'h700, 8'd2);
    checkOutput_done("post_reset_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
